// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_pkg                                                     |
// | Desc   : Opcodes, flag bit positions and FSM encoding for seq_alu.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOTA = 4'd7;
  localparam logic [3:0] OP_PASA = 4'd8;
  localparam logic [3:0] OP_PASB = 4'd9;
  localparam logic [3:0] OP_SLL  = 4'd10;
  localparam logic [3:0] OP_SRL  = 4'd11;
  localparam logic [3:0] OP_SRA  = 4'd12;
  localparam logic [3:0] OP_INC4 = 4'd13;
  localparam logic [3:0] OP_DEC4 = 4'd14;
  localparam logic [3:0] OP_POPC = 4'd15;

  // flags = {dz, ovf, carry, zero}
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_DZ    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seq_muldiv                                                  |
// | Desc   : W-cycle unsigned shift-add multiplier / restoring divider.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module seq_muldiv #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam int CW = $clog2(W);

  logic          r_busy;
  logic          r_div;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_b;

  logic [W:0]    w_sum;
  logic [W:0]    w_shift;
  logic [W:0]    w_trial;
  logic [W-1:0]  w_hi_nxt;
  logic [W-1:0]  w_lo_nxt;

  // hi:lo is the product (mul) or remainder:quotient (div)
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_shift = {r_hi, r_lo[W-1]};
  assign w_trial = w_shift - {1'b0, r_b};

  always_comb begin
    w_hi_nxt = w_sum[W:1];
    w_lo_nxt = {w_sum[0], r_lo[W-1:1]};
    if (r_div) begin
      w_hi_nxt = w_trial[W] ? w_shift[W-1:0] : w_trial[W-1:0];
      w_lo_nxt = {r_lo[W-2:0], ~w_trial[W]};
    end
  end

  // The result is taken from the final iteration's next-state so the
  // parent can register it on the same edge that leaves BUSY.
  assign done   = r_busy && (r_cnt == CW'(W - 1));
  assign result = w_lo_nxt;
  assign ovf    = !r_div && (|w_hi_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_div  <= is_div;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= a;
      r_b    <= b;
    end else if (r_busy) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seq_alu                                                     |
// | Desc   : Handshaked ALU, single-cycle ops plus iterative mul/div.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module seq_alu
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic [3:0]   flags
);

  localparam int SH = $clog2(W);

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_res;
  logic [3:0]   r_flags;

  logic         w_accept;
  logic         w_md_start;
  logic         w_md_done;
  logic [W-1:0] w_md_result;
  logic         w_md_ovf;
  logic [3:0]   w_md_flags;

  logic [W:0]    w_add;
  logic [W:0]    w_sub;
  logic [W-1:0]  w_x;
  logic [W-1:0]  w_pop;
  logic          w_big;
  logic [SH-1:0] w_shamt;
  logic [W-1:0]  w_fn_res;
  logic [3:0]    w_fn_flags;

  assign w_add   = {1'b0, a} + {1'b0, b};
  assign w_sub   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
  assign w_x     = a ^ b;
  assign w_big   = |(b >> SH);
  assign w_shamt = b[SH-1:0];

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++) w_pop = w_pop + W'(w_x[i]);
  end

  // Single-cycle function block, evaluated on the live inputs and
  // captured only on the accepting edge.
  always_comb begin
    w_fn_res   = '0;
    w_fn_flags = '0;
    case (op)
      OP_ADD: begin
        w_fn_res              = w_add[W-1:0];
        w_fn_flags[FLAG_CARRY] = w_add[W];
        w_fn_flags[FLAG_OVF]   = (a[W-1] == b[W-1]) && (w_add[W-1] != a[W-1]);
      end
      OP_SUB: begin
        w_fn_res              = w_sub[W-1:0];
        w_fn_flags[FLAG_CARRY] = w_sub[W];
        w_fn_flags[FLAG_OVF]   = (a[W-1] != b[W-1]) && (w_sub[W-1] != a[W-1]);
      end
      OP_DIV: begin
        w_fn_res            = '1;
        w_fn_flags[FLAG_DZ] = 1'b1;
      end
      OP_AND:  w_fn_res = a & b;
      OP_OR:   w_fn_res = a | b;
      OP_XOR:  w_fn_res = w_x;
      OP_NOTA: w_fn_res = ~a;
      OP_PASA: w_fn_res = a;
      OP_PASB: w_fn_res = b;
      OP_SLL:  w_fn_res = w_big ? '0 : (a << w_shamt);
      OP_SRL:  w_fn_res = w_big ? '0 : (a >> w_shamt);
      OP_SRA:  w_fn_res = w_big ? {W{a[W-1]}} : W'($signed(a) >>> w_shamt);
      OP_INC4: w_fn_res = a + W'(4);
      OP_DEC4: w_fn_res = a - W'(4);
      OP_POPC: w_fn_res = w_pop;
      default: ;
    endcase
    w_fn_flags[FLAG_ZERO] = (w_fn_res == '0);
  end

  always_comb begin
    w_md_flags            = '0;
    w_md_flags[FLAG_OVF]  = w_md_ovf;
    w_md_flags[FLAG_ZERO] = (w_md_result == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_md_start = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          // divide by zero short-circuits straight to DONE
          if (is_iterative(op) && !((op == OP_DIV) && (b == '0))) begin
            w_md_start = 1'b1;
            w_next     = ST_BUSY;
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_BUSY: if (w_md_done) w_next = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res   <= '0;
      r_flags <= '0;
    end else if (w_accept && !w_md_start) begin
      r_res   <= w_fn_res;
      r_flags <= w_fn_flags;
    end else if ((r_state == ST_BUSY) && w_md_done) begin
      r_res   <= w_md_result;
      r_flags <= w_md_flags;
    end
  end

  assign res   = r_res;
  assign flags = r_flags;

  seq_muldiv #(.W(W)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (w_md_start),
    .is_div (op == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (w_md_done),
    .result (w_md_result),
    .ovf    (w_md_ovf)
  );

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_seq_alu                                                  |
// | Desc   : Randomised self-checking bench for seq_alu at W=8.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [3:0] op, flags;
  logic [7:0] a, b, res;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {dz, ovf, carry, zero, res[7:0]} from integer arithmetic.
  function automatic logic [11:0] ref_alu(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int ux = x;
    int uy = y;
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int r = 0;
    int t;
    bit dz = 0, ov = 0, cy = 0;
    case (o)
      0:  begin r = ux + uy; cy = (r > 255); t = sx + sy; ov = (t > 127) || (t < -128); end
      1:  begin r = ux - uy; cy = (ux >= uy); t = sx - sy; ov = (t > 127) || (t < -128); end
      2:  begin r = ux * uy; ov = (r > 255); end
      3:  begin if (uy == 0) begin r = 255; dz = 1; end else r = ux / uy; end
      4:  r = ux & uy;
      5:  r = ux | uy;
      6:  r = ux ^ uy;
      7:  r = 255 - ux;
      8:  r = ux;
      9:  r = uy;
      10: r = (uy >= 8) ? 0 : (ux << uy);
      11: r = (uy >= 8) ? 0 : (ux >> uy);
      12: r = (uy >= 8) ? (sx < 0 ? -1 : 0) : (sx >>> uy);
      13: r = ux + 4;
      14: r = ux + 252;
      default: r = $countones(x ^ y);
    endcase
    r = r & 255;
    return {dz, ov, cy, (r == 0), 8'(r)};
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input int hold);
    logic [11:0] e;
    int exp_lat, lat;
    bit seen;
    e = ref_alu(o, x, y);
    exp_lat = ((o == 2) || (o == 3 && y != 0)) ? 9 : 1;
    op = o; a = x; b = y; in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'($urandom); op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk); lat++;
      if (out_valid) seen = 1;
      else begin
        chk("in_ready_busy", in_ready, 0);
        out_ready = 1'($urandom); in_valid = 1'($urandom);
      end
    end
    out_ready = 1'b0; in_valid = 1'b0;
    chk($sformatf("latency op%0d", o), lat, exp_lat);
    chk($sformatf("res op%0d %0h,%0h", o, x, y), res, e[7:0]);
    chk($sformatf("flags op%0d %0h,%0h", o, x, y), flags, e[11:8]);
    chk("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_res", res, e[7:0]);
      chk("hold_flags", flags, e[11:8]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("leave_valid", out_valid, 0);
    chk("leave_ready", in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    bit any;
    logic [7:0] rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_flags", flags, 0);
    rst = 1'b0;

    run_op(0, 8'h7F, 8'h01, 0);
    run_op(1, 8'h05, 8'h05, 1);
    run_op(2, 8'h10, 8'h20, 0);
    run_op(3, 8'd200, 8'd7, 0);
    run_op(3, 8'd5, 8'd0, 0);
    run_op(12, 8'h80, 8'd9, 5);
    run_op(10, 8'h81, 8'd8, 0);
    run_op(13, 8'hFE, 8'h00, 0);
    run_op(14, 8'h02, 8'h00, 0);
    run_op(2, 8'hFF, 8'hFF, 0);

    // reset in the 4th BUSY cycle of a multiply
    op = 4'd2; a = 8'h33; b = 8'h44; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_mul_busy", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_res", res, 0);
    @(negedge clk); rst = 1'b0;
    any = 0;
    repeat (12) begin @(negedge clk); if (out_valid) any = 1; end
    chk("no_result_after_rst", any, 0);
    run_op(0, 8'h12, 8'h34, 0);

    for (int i = 0; i < 150; i++) begin
      rb = ($urandom_range(2, 0) == 0) ? 8'($urandom_range(10, 0)) : 8'($urandom);
      run_op(4'($urandom), 8'($urandom), rb, int'($urandom_range(2, 0)));
    end

    // back-to-back single-cycle ops with out_ready tied high
    op = 4'd0; a = 8'd1; b = 8'd2; in_valid = 1'b1; out_ready = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (out_valid) cnt++; end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("throughput", cnt, 10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter W, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 Ports:
  - clk  input  1  rising-edge clock.
  - rst  input  1  asynchronous, active-high reset.
REQ-003 Ports:
  - in_valid  input  1  operation offered.
  - in_ready  output  1  block accepts operation.
  - op  input  4  opcode.
  - a  input  W  operand A.
  - b  input  W  operand B.
REQ-004 Ports:
  - out_valid  output  1  result available.
  - out_ready  input  1  consumer takes result.
  - res  output  W  result.
  - flags  output  4  {dz, ovf, carry, zero}.

Function
REQ-005 Opcodes: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 not A, 8 pass A, 9 pass B, 10 sll, 11 srl, 12 sra, 13 A+4, 14 A-4, 15 popcount(A^B).
REQ-006 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-007 Accept when in_valid&&in_ready; a, b and op SHALL be registered at acceptance; later input changes have no effect.
REQ-008 Single-cycle ops (all except 2, 3) accepted at cycle t: IDLE->DONE, out_valid=1 at t+1.
REQ-009 Mul/div accepted at cycle t: IDLE->BUSY, one iteration per cycle for W cycles, DONE with out_valid=1 at t+W+1.
REQ-010 Mul: unsigned shift-add, res = low W bits of A*B, ovf=1 iff high W bits nonzero.
REQ-011 Div: unsigned restoring, res = quotient.
REQ-012 Div with b==0: res all ones, dz=1, skip BUSY, out_valid at t+1.
REQ-013 Add/sub: carry = carry-out (sub: 1 = no borrow); ovf = signed overflow; both 0 for other ops except REQ-010.
REQ-014 zero = (res==0) for every op; dz=0 except REQ-012.
REQ-015 Shifts use b[clog2(W)-1:0] when b<W; b>=W gives 0 for sll/srl, all sign bits for sra.
REQ-016 Op 13/14 wrap modulo 2^W; op 15 result zero-extended to W.
REQ-017 In DONE, res/flags/out_valid SHALL hold stable until out_ready=1; DONE&&out_ready -> IDLE, in_ready=1 next cycle.
REQ-018 Back-to-back throughput: one single-cycle op per 2 cycles with out_ready tied high.
REQ-019 out_ready is ignored outside DONE; in_valid is ignored outside IDLE.

Reset
REQ-020 rst SHALL asynchronously force IDLE, in_ready=1, out_valid=0, res=0, flags=0, iteration counter=0.
REQ-021 rst asserted during BUSY or DONE SHALL abandon the operation with no result produced after release.
REQ-022 First accept is possible on the first rising edge after rst deasserts.

Structure
REQ-023 Opcode constants, flag bit indices and FSM state encoding SHALL live in shared package alu_pkg.
REQ-024 Iterative multiply/divide datapath SHALL be sub-module seq_muldiv (start, is_div, a, b -> done, result, ovf), parametrised by W.
REQ-025 Single-cycle ops SHALL be one combinational function block registered at the DONE transition.

Verification (W=8)
REQ-026 add a=0x7F b=0x01 -> res=0x80, ovf=1, carry=0, zero=0, out_valid one cycle after accept.
REQ-027 sub a=0x05 b=0x05 -> res=0x00, zero=1, carry=1.
REQ-028 mul a=0x10 b=0x20 -> res=0x00, ovf=1, zero=1, out_valid 9 cycles after accept; in_ready=0 throughout.
REQ-029 div a=200 b=7 -> res=28 after 9 cycles; div a=5 b=0 -> res=0xFF, dz=1 after 1 cycle.
REQ-030 sra a=0x80 b=9 -> res=0xFF; out_ready held low 5 cycles -> res/flags stable, then IDLE.
REQ-031 rst pulsed mid-mul (cycle 4 of BUSY) -> out_valid stays 0, in_ready=1 immediately, next op completes correctly.
